// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: byte FIFO feeding a frame FSM with runtime
// selectable data width (5..8), parity (none/even/odd) and one or two stop bits.
module uart_tx_cfg #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          baud_tick,
   input  logic                          tx_valid,
   input  logic [7:0]                    tx_data,
   output logic                          tx_ready,
   input  logic [1:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic [2:0]      last_q, last_d;
   logic            par_en_q, par_en_d;
   logic            par_bit_q, par_bit_d;
   logic            stop2_q, stop2_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;

   logic            push;
   logic            pop;
   logic            bit_end;
   logic [7:0]      head;
   logic [7:0]      mask;

   // Frame sequencing, FIFO bookkeeping and next-cycle output decode
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      data_d    = data_q;
      last_d    = last_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pop       = 1'b0;
      push      = tx_valid && ready_q;
      head      = mem_q[rd_ptr_q];
      bit_end   = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));

      unique case (cfg_data_bits)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase

      if (baud_tick && (state_q != S_IDLE)) begin
         tick_d = bit_end ? '0 : tick_q + TW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               data_d    = head;
               last_d    = 3'd4 + 3'(cfg_data_bits);
               par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
               par_bit_d = (^(head & mask)) ^ (cfg_parity == 2'b10);
               stop2_d   = cfg_stop2;
               tick_d    = '0;
               bit_d     = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == last_q) begin
                  bit_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            // bit_q doubles as the stop-bit index when two stop bits are used
            if (bit_end) begin
               if (stop2_q && (bit_q == 3'd0)) begin
                  bit_d = 3'd1;
               end else begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = tx_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
         S_PARITY: tx_d = par_bit_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
      ready_d = count_d < CW'(FIFO_DEPTH);
   end

   // Control state; reset aborts any frame and empties the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         last_q    <= 3'd7;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         last_q    <= last_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign tx         = tx_q;
   assign tx_busy    = busy_q;
   assign tx_ready   = ready_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of frames checked cycle by cycle,
// plus FIFO-full, reset-abort and mid-frame config sequences.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic [1:0] cfg_data_bits = 2'b11;
   logic [1:0] cfg_parity = 2'b00;
   logic       cfg_stop2 = 1'b0;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_count;

   int   checks = 0;
   int   errors = 0;
   int   period = 1;
   int   div = 0;
   logic tick_en = 1'b0;

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  bits;
      logic [1:0]  par;
      logic        stop2;
      int          per;
      bit          mid_cfg;
      logic [15:0] frame;   // line bits in send order, bit 0 = start bit
      int          len;
   } vec_t;

   vec_t vecs [8];
   vec_t v_after_rst;
   int   exp_cnt [6];
   logic exp_rdy [6];

   uart_tx_cfg #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .baud_tick     (baud_tick),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .tx            (tx),
      .tx_busy       (tx_busy),
      .fifo_count    (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) div <= (div >= period - 1) ? 0 : div + 1;
   assign baud_tick = tick_en && (div == period - 1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Send one byte and check every cycle of the frame against the table
   task automatic run_frame(input int idx, input vec_t v);
      int target;
      int bad;
      cfg_data_bits = v.bits;
      cfg_parity    = v.par;
      cfg_stop2     = v.stop2;
      period        = v.per;
      tick_en       = 1'b1;
      // align the write so the start bit begins on a fresh tick phase
      target = (v.per == 1) ? 0 : v.per - 2;
      @(negedge clk);
      for (int i = 0; i < v.per + 2 && div != target; i++) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = v.data;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      for (int b = 0; b < v.len; b++) begin
         bad = 0;
         if (v.mid_cfg && b == 3) begin
            cfg_data_bits = 2'b00;
            cfg_parity    = 2'b01;
            cfg_stop2     = 1'b1;
         end
         for (int c = 0; c < 16 * v.per; c++) begin
            if (tx !== v.frame[b] || tx_busy !== 1'b1) bad++;
            @(negedge clk);
         end
         chk($sformatf("v%0d_bit%0d_badcycles", idx, b), bad, 0);
      end
      chk($sformatf("v%0d_end_tx", idx), tx, 1);
      chk($sformatf("v%0d_end_busy", idx), tx_busy, 0);
   endtask

   // Receive one 8N1 byte (16 clocks per bit) and compare with the expected value
   task automatic rx_byte(input logic [7:0] exp);
      logic [7:0] d;
      int         n;
      n = 0;
      while (tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         chk($sformatf("rx_%0h_start_timeout", exp), tx, 0);
         return;
      end
      repeat (8) @(negedge clk);
      chk($sformatf("rx_%0h_start_mid", exp), tx, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clk);
         d[i] = tx;
      end
      chk($sformatf("rx_%0h_data", exp), d, exp);
      repeat (16) @(negedge clk);
      chk($sformatf("rx_%0h_stop", exp), tx, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;

      vecs[0] = '{8'h55, 2'b11, 2'b00, 1'b0, 1, 1'b0, 16'h02AA, 10};
      vecs[1] = '{8'hA3, 2'b10, 2'b01, 1'b1, 1, 1'b0, 16'h0746, 11};
      vecs[2] = '{8'h00, 2'b11, 2'b10, 1'b0, 1, 1'b0, 16'h0600, 11};
      vecs[3] = '{8'hFF, 2'b00, 2'b00, 1'b0, 1, 1'b0, 16'h007E, 7};
      vecs[4] = '{8'h2D, 2'b01, 2'b10, 1'b0, 1, 1'b0, 16'h01DA, 9};
      vecs[5] = '{8'h80, 2'b11, 2'b11, 1'b1, 1, 1'b0, 16'h0700, 11};
      vecs[6] = '{8'hFF, 2'b10, 2'b00, 1'b0, 1, 1'b0, 16'h01FE, 9};
      vecs[7] = '{8'h55, 2'b11, 2'b00, 1'b0, 3, 1'b1, 16'h02AA, 10};
      v_after_rst = '{8'h96, 2'b11, 2'b00, 1'b0, 1, 1'b0, 16'h032C, 10};
      exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2;
      exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
      exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_busy", tx_busy, 0);
      chk("reset_ready", tx_ready, 1);
      chk("reset_count", fifo_count, 0);

      for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

      // FIFO fill with ticks stalled: byte 0 pops at once, 1..4 fill, 5 dropped
      cfg_data_bits = 2'b11;
      cfg_parity    = 2'b00;
      cfg_stop2     = 1'b0;
      period        = 1;
      tick_en       = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         tx_valid = 1'b1;
         tx_data  = 8'(k);
         @(negedge clk);
         chk($sformatf("fill%0d_count", k), fifo_count, exp_cnt[k]);
         chk($sformatf("fill%0d_ready", k), tx_ready, exp_rdy[k]);
      end
      tx_valid = 1'b0;
      @(negedge clk);
      chk("fill_start_held_tx", tx, 0);
      chk("fill_busy", tx_busy, 1);
      tick_en = 1'b1;
      for (int k = 0; k < 5; k++) rx_byte(8'(k));
      repeat (10) @(negedge clk);
      chk("fill_drain_busy", tx_busy, 0);
      chk("fill_drain_count", fifo_count, 0);

      // Reset during DATA bit 3 with a second byte still queued
      tx_valid = 1'b1;
      tx_data  = 8'hC3;
      @(negedge clk);
      tx_data  = 8'h3C;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (70) @(negedge clk);
      chk("abort_pre_bit3_tx", tx, 0);
      chk("abort_pre_count", fifo_count, 1);
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
      @(negedge clk);
      rst      = 1'b0;
      tx_valid = 1'b0;
      chk("abort_tx", tx, 1);
      chk("abort_busy", tx_busy, 0);
      chk("abort_count", fifo_count, 0);
      chk("abort_ready", tx_ready, 1);
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("abort_quiet_badcycles", bad, 0);
      run_frame(8, v_after_rst);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
